// File: rtl/i2c_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_seq_pkg
// Brief    : Shared state encoding and default parameters for the I2C
//            register-read sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package i2c_seq_pkg;

    localparam int c_timeout_cyc_default = 64;
    localparam int c_len_w_default       = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_W_ADDR  = 3'd1,
        ST_W_REG   = 3'd2,
        ST_RESTART = 3'd3,
        ST_R_ADDR  = 3'd4,
        ST_R_DATA  = 3'd5,
        ST_FINISH  = 3'd6,
        ST_ABORT   = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/i2c_seq_wdog.sv
`default_nettype none
// ============================================================================
// Module   : i2c_seq_wdog
// Brief    : Cycle watchdog; flags the TIMEOUT_CYC-th enabled cycle since clear.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_seq_wdog #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int                 c_cnt_w = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(TIMEOUT_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable && (r_cnt != c_last)) begin
            r_cnt <= r_cnt + c_one;
        end
    end

    // High during the final permitted cycle; the owner decides whether an ack rescues it.
    assign expired = enable && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/i2c_reg_seq.sv
`default_nettype none
// ============================================================================
// Module   : i2c_reg_seq
// Brief    : Sequences an I2C register read (write pointer, repeated start,
//            burst read) on a byte-level master, with a per-byte watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_reg_seq
    import i2c_seq_pkg::*;
#(
    parameter int TIMEOUT_CYC = c_timeout_cyc_default,
    parameter int LEN_W       = c_len_w_default
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [6:0]       dev_addr,
    input  logic [7:0]       reg_addr,
    input  logic [LEN_W-1:0] rd_len,
    output logic             busy,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             done,
    output logic             nack_err,
    output logic [6:0]       m_address,
    output logic [7:0]       m_register,
    output logic             m_mode,
    output logic             m_en,
    output logic             m_start,
    output logic             m_repeat_start,
    output logic             m_stop,
    input  logic             m_ack,
    input  logic [7:0]       m_data
);

    localparam int                 c_cnt_w   = LEN_W + 1;
    localparam logic [c_cnt_w-1:0] c_one     = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_len_max = c_cnt_w'(2 ** LEN_W);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [c_cnt_w-1:0] w_len_full;
    logic [LEN_W-1:0]   r_len;
    logic [6:0]         r_addr;
    logic [7:0]         r_reg;
    logic [7:0]         r_rd_data;
    logic               r_busy, r_en, r_start, r_rstart, r_stop, r_mode;
    logic               r_done, r_nack, r_rd_valid;
    logic               w_mode_nxt;
    logic               w_wait;
    logic               w_expired;

    assign w_wait     = (r_state == ST_W_ADDR) || (r_state == ST_W_REG) ||
                        (r_state == ST_R_ADDR) || (r_state == ST_R_DATA);
    assign w_len_full = (r_len == '0) ? c_len_max : {1'b0, r_len};

    i2c_seq_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clear   ((r_state == ST_IDLE) || (w_wait && m_ack)),
        .enable  (w_wait),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // An ack always wins over a simultaneous watchdog expiry.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (req) w_state_nxt = ST_W_ADDR;
            end
            ST_W_ADDR: begin
                if (m_ack)          w_state_nxt = ST_W_REG;
                else if (w_expired) w_state_nxt = ST_ABORT;
            end
            ST_W_REG: begin
                if (m_ack)          w_state_nxt = ST_RESTART;
                else if (w_expired) w_state_nxt = ST_ABORT;
            end
            ST_RESTART: begin
                w_state_nxt = ST_R_ADDR;
            end
            ST_R_ADDR: begin
                if (m_ack) begin
                    w_state_nxt = ST_R_DATA;
                    w_cnt_nxt   = w_len_full;
                end else if (w_expired) begin
                    w_state_nxt = ST_ABORT;
                end
            end
            ST_R_DATA: begin
                if (m_ack) begin
                    w_cnt_nxt = r_cnt - c_one;
                    if (r_cnt == c_one) w_state_nxt = ST_FINISH;
                end else if (w_expired) begin
                    w_state_nxt = ST_ABORT;
                end
            end
            ST_FINISH, ST_ABORT: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_mode_nxt = r_mode;
        case (w_state_nxt)
            ST_IDLE, ST_W_ADDR, ST_W_REG: w_mode_nxt = 1'b0;
            ST_RESTART:                   w_mode_nxt = 1'b1;
            default:                      w_mode_nxt = r_mode;
        endcase
    end

    // Outputs are registered from the next state so they align with the state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt      <= '0;
            r_len      <= '0;
            r_addr     <= '0;
            r_reg      <= '0;
            r_rd_data  <= '0;
            r_busy     <= 1'b0;
            r_en       <= 1'b0;
            r_start    <= 1'b0;
            r_rstart   <= 1'b0;
            r_stop     <= 1'b0;
            r_mode     <= 1'b0;
            r_done     <= 1'b0;
            r_nack     <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_en       <= (w_state_nxt != ST_IDLE);
            r_start    <= (r_state == ST_IDLE) && req;
            r_rstart   <= (w_state_nxt == ST_RESTART);
            r_mode     <= w_mode_nxt;
            r_stop     <= (w_state_nxt == ST_ABORT) ||
                          ((w_state_nxt == ST_R_DATA) && (w_cnt_nxt == c_one));
            r_done     <= (w_state_nxt == ST_FINISH) || (w_state_nxt == ST_ABORT);
            r_nack     <= (w_state_nxt == ST_ABORT);
            r_rd_valid <= (r_state == ST_R_DATA) && m_ack;
            if ((r_state == ST_R_DATA) && m_ack) begin
                r_rd_data <= m_data;
            end
            if ((r_state == ST_IDLE) && req) begin
                r_addr <= dev_addr;
                r_reg  <= reg_addr;
                r_len  <= rd_len;
            end
        end
    end

    assign busy           = r_busy;
    assign rd_data        = r_rd_data;
    assign rd_valid       = r_rd_valid;
    assign done           = r_done;
    assign nack_err       = r_nack;
    assign m_address      = r_addr;
    assign m_register     = r_reg;
    assign m_mode         = r_mode;
    assign m_en           = r_en;
    assign m_start        = r_start;
    assign m_repeat_start = r_rstart;
    assign m_stop         = r_stop;

endmodule
`default_nettype wire

// File: tb/tb_i2c_reg_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_reg_seq
// Brief    : Scoreboard bench for i2c_reg_seq; stimulus queues expected
//            bytes/done events, a negedge monitor retires them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_reg_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req = 1'b0;
    logic [6:0] dev_addr = '0;
    logic [7:0] reg_addr = '0;
    logic [2:0] rd_len = '0;
    logic       m_ack = 1'b0;
    logic [7:0] m_data = '0;
    logic       busy, rd_valid, done, nack_err, m_mode, m_en;
    logic       m_start, m_repeat_start, m_stop;
    logic [7:0] rd_data, m_register;
    logic [6:0] m_address;

    i2c_reg_seq #(
        .TIMEOUT_CYC (64),
        .LEN_W       (3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .dev_addr       (dev_addr),
        .reg_addr       (reg_addr),
        .rd_len         (rd_len),
        .busy           (busy),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .done           (done),
        .nack_err       (nack_err),
        .m_address      (m_address),
        .m_register     (m_register),
        .m_mode         (m_mode),
        .m_en           (m_en),
        .m_start        (m_start),
        .m_repeat_start (m_repeat_start),
        .m_stop         (m_stop),
        .m_ack          (m_ack),
        .m_data         (m_data)
    );

    always #5 clk = ~clk;

    // kind: 0 = read byte, 1 = normal done, 2 = abort done; cyc < 0 means untimed
    typedef struct {
        int kind;
        int data;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   n_start = 0;
    int   n_rstart = 0;
    int   n_stop = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_unexpected(input string name, input int act);
        checks++;
        failures++;
        $display("FAIL %s: got 0x%0h expected no event (cycle %0d)", name, act, cyc);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (m_start)        n_start++;
        if (m_repeat_start) n_rstart++;
        if (m_stop)         n_stop++;
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                fail_unexpected("unexpected_rd_valid", int'(rd_data));
            end else begin
                e = exp_q.pop_front();
                check("rd_event_kind", 0, e.kind);
                check("rd_data", int'(rd_data), e.data);
            end
        end
        if (done) begin
            if (exp_q.size() == 0) begin
                fail_unexpected("unexpected_done", int'(nack_err));
            end else begin
                e = exp_q.pop_front();
                check("done_kind", nack_err ? 2 : 1, e.kind);
                if (e.cyc >= 0) check("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Raise m_ack in the d-th cycle counted from the current one.
    task automatic ack_at(input int d, input logic [7:0] data, input bit chk_stop, input bit exp_stop);
        repeat (d - 1) @(negedge clk);
        m_ack  = 1'b1;
        m_data = data;
        if (chk_stop) begin
            check("m_stop_at_ack", int'(m_stop), int'(exp_stop));
            check("m_mode_read", int'(m_mode), 1);
        end
        @(negedge clk);
        m_ack  = 1'b0;
        m_data = '0;
    endtask

    task automatic wait_drain(input int limit);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < limit) begin
            @(negedge clk);
            k++;
        end
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    task automatic run_read(input logic [6:0] da, input logic [7:0] ra, input logic [2:0] len,
                            input int d_first, input int d_rest, input logic [7:0] seed,
                            input bit ack_restart, input bit req_mid);
        int         n;
        int         s0;
        int         r0;
        logic [7:0] b;
        n  = (len == 3'd0) ? 8 : int'(len);
        s0 = n_start;
        r0 = n_rstart;
        dev_addr = da;
        reg_addr = ra;
        rd_len   = len;
        req      = 1'b1;
        @(negedge clk);
        req      = 1'b0;
        dev_addr = '0;
        reg_addr = '0;
        rd_len   = '0;
        check("m_start_first_cycle", int'(m_start), 1);
        check("busy_first_cycle", int'(busy), 1);
        check("m_mode_write", int'(m_mode), 0);
        ack_at(d_first, 8'h00, 1'b0, 1'b0);
        check("m_address_held", int'(m_address), int'(da));
        check("m_register_held", int'(m_register), int'(ra));
        ack_at(d_rest, 8'h00, 1'b0, 1'b0);
        if (ack_restart) ack_at(1, 8'hEE, 1'b0, 1'b0);
        ack_at(d_rest, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            if (req_mid && i == 1) begin
                req = 1'b1;
                @(negedge clk);
                req = 1'b0;
            end
            b = seed + 8'(i * 19);
            exp_q.push_back('{0, int'(b), -1});
            if (i == n - 1) exp_q.push_back('{1, 0, -1});
            ack_at(d_rest, b, 1'b1, (i == n - 1));
        end
        wait_drain(100);
        repeat (2) @(negedge clk);
        check("busy_after_done", int'(busy), 0);
        check("m_en_after_done", int'(m_en), 0);
        check("m_start_count", n_start - s0, 1);
        check("m_repeat_start_count", n_rstart - r0, 1);
    endtask

    initial begin : global_timeout
        #500000;
        $display("FAIL global_timeout: got no finish expected finish (cycle %0d)", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin : stimulus
        int s0;
        repeat (3) @(negedge clk);
        check("reset_outputs_zero",
              int'({busy, rd_valid, done, nack_err, m_en, m_start, m_repeat_start, m_stop, m_mode,
                    rd_data, m_address, m_register}), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Two-byte read, ack spacing 18/9/9/9/9
        run_read(7'h48, 8'h0F, 3'd2, 18, 9, 8'hA5, 1'b0, 1'b0);

        // Length code 0 reads eight bytes
        run_read(7'h21, 8'h80, 3'd0, 2, 2, 8'h10, 1'b0, 1'b0);

        // No ack after start: abort 64 cycles after W_ADDR entry
        s0       = n_stop;
        dev_addr = 7'h50;
        reg_addr = 8'h01;
        rd_len   = 3'd2;
        req      = 1'b1;
        exp_q.push_back('{2, 0, cyc + 65});
        @(negedge clk);
        req = 1'b0;
        wait_drain(100);
        @(negedge clk);
        check("abort_stop_cycles", n_stop - s0, 1);
        check("abort_m_en_low", int'(m_en), 0);
        check("abort_busy_low", int'(busy), 0);
        repeat (2) @(negedge clk);

        // Ack lands in the 64th W_ADDR cycle: must be honoured
        run_read(7'h3C, 8'hA0, 3'd1, 64, 4, 8'h77, 1'b0, 1'b0);

        // Stray ack in RESTART and req during R_DATA are both ignored
        run_read(7'h55, 8'h44, 3'd3, 5, 4, 8'hC0, 1'b1, 1'b1);

        // Reset in the middle of R_DATA
        dev_addr = 7'h22;
        reg_addr = 8'h33;
        rd_len   = 3'd4;
        req      = 1'b1;
        @(negedge clk);
        req = 1'b0;
        ack_at(3, 8'h00, 1'b0, 1'b0);
        ack_at(3, 8'h00, 1'b0, 1'b0);
        ack_at(3, 8'h00, 1'b0, 1'b0);
        exp_q.push_back('{0, 32'h5A, -1});
        ack_at(3, 8'h5A, 1'b0, 1'b0);
        wait_drain(10);
        reset = 1'b0;
        @(negedge clk);
        check("midreset_outputs_zero",
              int'({busy, rd_valid, done, nack_err, m_en, m_start, m_repeat_start, m_stop, m_mode,
                    rd_data, m_address, m_register}), 0);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("midreset_no_events", exp_q.size(), 0);

        run_read(7'h11, 8'h22, 3'd1, 3, 3, 8'h9D, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_reg_seq.md
I2C_REG_SEQ -- requirements
Module: i2c_reg_seq

Interface
REQ-001 Parameter TIMEOUT_CYC, default 64: clk cycles allowed between consecutive m_ack pulses before abort.
REQ-002 Parameter LEN_W, default 3: width of rd_len; value 0 encodes 2**LEN_W bytes.
REQ-003 clk  in  1  system clock; also drives the downstream I2C master.
REQ-004 reset  in  1  reset, synchronous, active-low.
REQ-005 req  in  1  host request; sampled only in IDLE.
REQ-006 dev_addr  in  7  target 7-bit device address.
REQ-007 reg_addr  in  8  target register pointer.
REQ-008 rd_len  in  LEN_W  number of bytes to read (0 = 2**LEN_W).
REQ-009 busy  out  1  transaction in progress.
REQ-010 rd_data  out  8  captured read byte.
REQ-011 rd_valid  out  1  one-cycle strobe qualifying rd_data.
REQ-012 done  out  1  one-cycle strobe at end of transaction.
REQ-013 nack_err  out  1  one-cycle strobe, coincident with done, on timeout abort.
REQ-014 m_address  out  7  to master address.
REQ-015 m_register  out  8  to master register byte.
REQ-016 m_mode  out  1  to master mode (0 write, 1 read).
REQ-017 m_en  out  1  to master enable.
REQ-018 m_start, m_repeat_start, m_stop  out  1 each  to master control strobes.
REQ-019 m_ack  in  1  master end-of-byte pulse, one cycle per address/register/data byte.
REQ-020 m_data  in  8  master read byte; valid in the cycle m_ack is high during a read-data phase.

Function
REQ-021 FSM states SHALL be IDLE, W_ADDR, W_REG, RESTART, R_ADDR, R_DATA, FINISH, ABORT.
REQ-022 IDLE: on req=1, latch dev_addr/reg_addr/rd_len, drive m_en=1, m_mode=0, m_start=1 for exactly one cycle; go to W_ADDR; busy=1 from the next cycle.
REQ-023 W_ADDR: on m_ack, go to W_REG.
REQ-024 W_REG: on m_ack, go to RESTART.
REQ-025 RESTART: one cycle; m_repeat_start=1 and m_mode=1 for that cycle; go to R_ADDR; m_mode stays 1 until FINISH.
REQ-026 R_ADDR: on m_ack, go to R_DATA with byte counter = latched length.
REQ-027 R_DATA: each m_ack captures m_data into rd_data and pulses rd_valid in the next cycle; counter decrements.
REQ-028 m_stop SHALL be high throughout R_DATA while counter = 1, i.e. before the last byte's m_ack; the final m_ack goes to FINISH.
REQ-029 FINISH: one cycle; done=1, m_en=0, busy=0 next cycle; return to IDLE.
REQ-030 Watchdog: cleared on entry to W_ADDR and on every m_ack; in any wait state, reaching TIMEOUT_CYC cycles without m_ack goes to ABORT.
REQ-031 ABORT: one cycle; m_stop=1, done=1, nack_err=1; m_en=0 next cycle; return to IDLE; bytes already strobed remain valid.
REQ-032 req while busy=1 SHALL be ignored, not queued.
REQ-033 m_ack in the same cycle the watchdog expires SHALL be honoured; no abort.
REQ-034 m_ack outside a wait state SHALL be ignored.
REQ-035 m_address/m_register SHALL hold latched values from request until return to IDLE.

Reset
REQ-036 reset=0 at a clk edge SHALL force IDLE; all outputs 0 (rd_data 8'h00); counters 0; no done strobe, including mid-transaction.

Structure
REQ-037 Package i2c_seq_pkg SHALL hold the state encoding and the TIMEOUT_CYC default.
REQ-038 The watchdog SHALL be a sub-module i2c_seq_wdog (clear, enable, expired).

Verification
REQ-039 dev_addr=7'h48, reg_addr=8'h0F, rd_len=2, m_ack at delays 18/9/9/9/9 -> one m_start, one m_repeat_start, rd_valid twice with the m_data values, m_stop during 2nd byte, done=1, nack_err=0.
REQ-040 rd_len=0 -> exactly 8 rd_valid strobes before done.
REQ-041 No m_ack after m_start -> ABORT at cycle 64 after W_ADDR entry; done=nack_err=1, m_stop=1 for one cycle.
REQ-042 m_ack arrives in exactly the 64th cycle -> no abort; transaction completes.
REQ-043 req pulsed during R_DATA -> ignored; single done.
REQ-044 reset=0 during R_DATA -> next cycle all outputs 0, IDLE; a new req completes normally.
